// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, single outstanding miss.
// Define ICACHE_STAT_EN to add the hit_cnt/miss_cnt lookup counters.
module icache #(
  parameter int unsigned ICACHE_SIZE_LOG = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_rst,
  input  logic        IF_valid,
  input  logic [31:0] IF_addr,
  output logic        IF_send,
  output logic [31:0] IF_inst,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  input  logic        mem_ready,
`ifdef ICACHE_STAT_EN
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt,
`endif
  input  logic [31:0] mem_inst
);

  localparam int unsigned Lines = 1 << ICACHE_SIZE_LOG;
  localparam int unsigned TagW  = 16 - ICACHE_SIZE_LOG;

  typedef enum logic [1:0] {StIdle, StMiss, StResp} state_e;

  state_e state_q, state_d;

  logic [Lines-1:0] valid_q, valid_d;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [31:0]      data_q [Lines];

  logic        if_send_q, if_send_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        mem_valid_q, mem_valid_d;
  logic [31:0] mem_addr_q, mem_addr_d;

  logic [ICACHE_SIZE_LOG-1:0] lk_idx, fill_idx;
  logic [TagW-1:0]            lk_tag, fill_tag;
  logic                       hit;
  logic                       lookup;
  logic                       fill_en;

  // Address bits outside the tag/index range do not take part in the lookup.
  logic unused_addr;
  assign unused_addr = ^{IF_addr[31:18], IF_addr[1:0]};

  assign lk_idx   = IF_addr[ICACHE_SIZE_LOG+1:2];
  assign lk_tag   = IF_addr[17:ICACHE_SIZE_LOG+2];
  assign fill_idx = mem_addr_q[ICACHE_SIZE_LOG+1:2];
  assign fill_tag = mem_addr_q[17:ICACHE_SIZE_LOG+2];
  assign hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lookup   = (state_q == StIdle) && IF_valid && !jump_rst;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (jump_rst) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: if (IF_valid) state_d = hit ? StResp : StMiss;
        StMiss: if (mem_ready) state_d = StResp;
        StResp: state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Output and array-update logic; IF_send is a pulse so it defaults low.
  always_comb begin
    if_send_d   = 1'b0;
    if_inst_d   = if_inst_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    valid_d     = valid_q;
    fill_en     = 1'b0;
    if (jump_rst) begin
      mem_valid_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (IF_valid) begin
            if (hit) begin
              if_send_d = 1'b1;
              if_inst_d = data_q[lk_idx];
            end else begin
              mem_valid_d = 1'b1;
              mem_addr_d  = IF_addr;
            end
          end
        end
        StMiss: begin
          if (mem_ready) begin
            fill_en           = 1'b1;
            valid_d[fill_idx] = 1'b1;
            mem_valid_d       = 1'b0;
            if_inst_d         = mem_inst;
            if_send_d         = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      if_send_q   <= 1'b0;
      if_inst_q   <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
    end else if (rdy) begin
      valid_q     <= valid_d;
      if_send_q   <= if_send_d;
      if_inst_q   <= if_inst_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // Tag/data need no reset: the valid bits gate every read.
  always_ff @(posedge clk) begin
    if (rdy && fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= mem_inst;
    end
  end

  assign IF_send   = if_send_q;
  assign IF_inst   = if_inst_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;

`ifdef ICACHE_STAT_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (lookup) begin
      if (hit) hit_cnt_d = hit_cnt_q + 32'd1;
      else     miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rdy) begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;
`else
  logic unused_lookup;
  assign unused_lookup = lookup;
`endif

endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter ICACHE_SIZE_LOG, default 6, meaning log2 of the number of lines (one 32-bit word per line, direct-mapped).
REQ-002 SHALL have port clk, input, 1, the single system clock (all state on rising edge).
REQ-003 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port rdy, input, 1, which freezes all state when low.
REQ-005 SHALL have port jump_rst, input, 1, the ROB mispredict flush.
REQ-006 SHALL have port IF_valid, input, 1, the fetch request from IF, held until IF_send.
REQ-007 SHALL have port IF_addr, input, 32, the fetch PC (word-aligned).
REQ-008 SHALL have port IF_send, output, 1, a one-cycle pulse meaning IF_inst is valid.
REQ-009 SHALL have port IF_inst, output, 32, the instruction returned to IF.
REQ-010 SHALL have port mem_valid, output, 1, the fetch request to Memctrl, held until mem_ready.
REQ-011 SHALL have port mem_addr, output, 32, the miss address to Memctrl.
REQ-012 SHALL have port mem_ready, input, 1, a one-cycle pulse from Memctrl meaning mem_inst is valid.
REQ-013 SHALL have port mem_inst, input, 32, the word fetched by Memctrl.

Function
REQ-014 SHALL compute index = IF_addr[ICACHE_SIZE_LOG+1:2] and tag = IF_addr[17:ICACHE_SIZE_LOG+2] (10 bits at default); IF_addr[31:18] and [1:0] are ignored.
REQ-015 SHALL store a valid bit, tag and data word per line.
REQ-016 SHALL implement states IDLE, MISS and RESP.
REQ-017 IDLE, IF_valid=1, hit (valid and tag match): SHALL register data to IF_inst, pulse IF_send next cycle, and enter RESP (hit latency 1 cycle).
REQ-018 IDLE, IF_valid=1, miss: SHALL latch IF_addr into mem_addr, set mem_valid=1 next cycle, and enter MISS.
REQ-019 MISS: SHALL hold mem_valid and mem_addr stable until mem_ready.
REQ-020 MISS with mem_ready=1: SHALL write the line (valid=1, tag, mem_inst), clear mem_valid, set IF_inst=mem_inst, pulse IF_send next cycle, and enter RESP.
REQ-021 RESP: SHALL clear IF_send after one cycle, ignore IF_valid for that cycle, and return to IDLE (gives IF one cycle to update its PC).
REQ-022 IF_valid in MISS or RESP SHALL be ignored; no second outstanding miss.
REQ-023 jump_rst=1 in any state SHALL take priority: next cycle state=IDLE, mem_valid=0, IF_send=0, no line write even if mem_ready coincides; cache contents preserved.
REQ-024 rdy=0 SHALL hold state, outputs and array unchanged; mem_ready during rdy=0 is not expected and need not be captured.
REQ-025 mem_ready outside MISS SHALL be ignored.
REQ-026 SHALL implement no writes from SLB; self-modifying code is unsupported.

Reset
REQ-027 rst=1 SHALL asynchronously clear all valid bits, state=IDLE, IF_send=0, IF_inst=0, mem_valid=0, mem_addr=0.
REQ-028 rst asserted mid-miss SHALL abandon the request; the first request after deassertion misses.

Configuration
REQ-029 Macro ICACHE_STAT_EN defined SHALL add outputs hit_cnt[31:0] and miss_cnt[31:0]: reset to 0, increment once per accepted IDLE lookup (hit or miss respectively), frozen while rdy=0, wrap at 2^32, not cleared by jump_rst.
REQ-030 Macro ICACHE_STAT_EN undefined SHALL omit these ports and counters, with otherwise identical behaviour.

Verification
REQ-031 Cold miss: IF_addr=0x00000100 after reset -> mem_valid=1, mem_addr=0x100; mem_ready with mem_inst=0x00000013 -> IF_send pulse next cycle, IF_inst=0x00000013.
REQ-032 Hit: re-request 0x100 -> IF_send exactly 1 cycle after IF_valid, IF_inst=0x00000013, mem_valid stays 0.
REQ-033 Conflict: fill 0x100, then request 0x200 (same index 0, different tag) -> miss; afterwards 0x100 misses again.
REQ-034 Flush: miss on 0x300, jump_rst pulsed in the same cycle as mem_ready -> no IF_send; a later request to 0x300 misses.
REQ-035 Stall: rdy=0 for 5 cycles during MISS -> mem_valid and mem_addr unchanged and no IF_send; completion follows once rdy=1.
REQ-036 Stats (ICACHE_STAT_EN): scenarios 031-033 in sequence -> hit_cnt=1, miss_cnt=3.
